// File: rtl/alu_result_writeback.sv
// In-order FIFO between ALU result completion and the register-file write port.
// One-cycle minimum latency, no bypass; in_ready drops at full even if the head is popping that cycle.
module alu_result_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              zero_out,
  output logic [ADDR_W:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            storage [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              push;
  logic              pop;

  // Ready/valid come from the registered count only, so there is no combinational in->out path.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_data   = storage[rd_ptr].data;
  assign wr_addr   = storage[rd_ptr].dest;
  assign zero_out  = out_valid && (wr_data == '0);
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= '{dest: dest_in, data: result_in};
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Directed bench for alu_result_writeback: queue-based reference model checked every cycle plus literal pins.
module tb_alu_result_writeback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result_in;
  logic [2:0] dest_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] wr_data;
  logic [2:0] wr_addr;
  logic       zero_out;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  logic [10:0] q[$];

  alu_result_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result_in (result_in),
    .dest_in   (dest_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .zero_out  (zero_out),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of {dest,data}; decisions use only model occupancy and inputs.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        q.delete();
      end else begin
        automatic bit do_push = in_valid && (q.size() < 4);
        automatic bit do_pop  = out_ready && (q.size() > 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({dest_in, result_in});
      end
    end
  end

  always @(negedge clk) begin
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_in_ready", 32'(in_ready), 32'(q.size() != 4));
    chk("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("m_wr_data", 32'(wr_data), 32'(q[0][7:0]));
      chk("m_wr_addr", 32'(wr_addr), 32'(q[0][10:8]));
      chk("m_zero_out", 32'(zero_out), 32'(q[0][7:0] == 8'h00));
    end else begin
      chk("m_zero_out_empty", 32'(zero_out), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_held(input logic [7:0] d, input logic [2:0] a);
    in_valid  = 1'b1;
    result_in = d;
    dest_in   = a;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    result_in = '0; dest_in = '0;
    repeat (2) tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_zero_out", 32'(zero_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single pass with the consumer already ready.
    out_ready = 1'b1;
    push_held(8'hA5, 3'd5);
    chk("pass_out_valid", 32'(out_valid), 32'd1);
    chk("pass_wr_addr", 32'(wr_addr), 32'd5);
    chk("pass_wr_data", 32'(wr_data), 32'hA5);
    chk("pass_count1", 32'(count), 32'd1);
    tick();
    chk("pass_count0", 32'(count), 32'd0);
    chk("pass_empty", 32'(out_valid), 32'd0);

    // Fill to full, fifth entry held, then drain in order.
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push_held(8'(k), 3'(k));
    in_valid = 1'b1; result_in = 8'h05; dest_in = 3'd5;
    tick(); tick();
    chk("fill_count4", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      automatic bit acc = in_valid && in_ready;
      chk("drain_order", 32'(wr_data), 32'(i + 1));
      tick();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("drain_done", 32'(count), 32'd0);

    // Concurrent push/pop at count 2 across pointer wrap.
    out_ready = 1'b0;
    push_held(8'h30, 3'd0);
    push_held(8'h31, 3'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      result_in = 8'(8'h20 + i);
      dest_in   = 3'(i);
      chk("conc_count", 32'(count), 32'd2);
      chk("conc_head", 32'(wr_data), (i < 2) ? 32'(8'h30 + i) : 32'(8'h20 + i - 2));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("conc_drained", 32'(count), 32'd0);

    // Zero flag follows the head entry.
    out_ready = 1'b0;
    push_held(8'h00, 3'd3);
    chk("zero_set", 32'(zero_out), 32'd1);
    chk("zero_addr", 32'(wr_addr), 32'd3);
    push_held(8'h10, 3'd4);
    chk("zero_still_head", 32'(zero_out), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("zero_clear", 32'(zero_out), 32'd0);
    chk("zero_next_head", 32'(wr_data), 32'h10);
    tick();

    // Flush overrides a same-cycle push and pop.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_held(8'(8'h40 + k), 3'(k));
    chk("flush_pre", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; result_in = 8'h77; dest_in = 3'd7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("flush_nothing_stored", 32'(count), 32'd0);

    // Asynchronous reset mid-stream takes effect before the next edge.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_held(8'(8'h50 + k), 3'(k));
    chk("arst_pre", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    push_held(8'h66, 3'd6);
    chk("arst_resume_data", 32'(wr_data), 32'h66);
    out_ready = 1'b1;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
